// File: rtl/ebr_block_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ebr_block_reader
//  Purpose  : Reads one 8-line pixel strip out of the dual-port EBR line
//             buffer and re-orders it into 8x8 blocks (block order, raster
//             order inside each block) on a valid/ready stream for the DCT.
//             Absorbs the EBR's 1-cycle read latency with a 2-entry skid
//             FIFO and a credit check so no sample is lost or duplicated.
//  Revision : 1.0  initial release
// ============================================================================
module ebr_block_reader #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int IMAGE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  strip_valid,
    output logic                  strip_done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  dout_last_block
);

    // Controller states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // Distance between strip rows in the EBR, and the index of the last block
    localparam logic [ADDR_WIDTH-1:0] c_row_stride = ADDR_WIDTH'(IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_blk_max    = ADDR_WIDTH'(IMAGE_WIDTH / 8 - 1);

    // Controller and address counters; the counters always describe the
    // address currently presented on raddr.
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_blk;
    logic [2:0]            r_row;
    logic [2:0]            r_col;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_strip_done;

    // Read tracking: flags ride with the read while rdata is in flight
    logic                  r_in_flight;
    logic                  r_if_last;
    logic                  r_if_last_block;

    // Two-entry skid FIFO (head drives the outputs directly)
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_last;
    logic                  r_head_last_block;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_tail_last;
    logic                  r_tail_last_block;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_credit;
    logic                  w_issue;
    logic [2:0]            w_occupancy;
    logic                  w_is_last;
    logic                  w_is_last_block;
    logic                  w_is_final;
    logic                  w_final_pop;
    logic                  w_col_wrap;
    logic                  w_row_wrap;
    logic [2:0]            w_col_nxt;
    logic [2:0]            w_row_nxt;
    logic [ADDR_WIDTH-1:0] w_blk_nxt;

    // EBR address of a (block, row, column) position in the raster strip
    function automatic logic [ADDR_WIDTH-1:0] f_addr(
        input logic [ADDR_WIDTH-1:0] blk,
        input logic [2:0]            row,
        input logic [2:0]            col
    );
        return (ADDR_WIDTH'(row) * c_row_stride) + (blk << 3) + ADDR_WIDTH'(col);
    endfunction

    assign w_pop  = dout_valid & dout_ready;
    assign w_push = r_in_flight;

    // Slots already committed (stored + in flight) must stay below 2 after
    // this cycle's pop, otherwise the returning read would have nowhere to go.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_in_flight};
    assign w_credit    = w_occupancy < (3'd2 + {2'b00, w_pop});
    assign w_issue     = (r_state == c_st_read) & w_credit;

    assign w_is_last       = (r_col == 3'd7) & (r_row == 3'd7);
    assign w_is_last_block = (r_blk == c_blk_max);
    assign w_is_final      = w_is_last & w_is_last_block;

    // Column fastest, then row, then block; wraps to 0 after the final address
    assign w_col_wrap = (r_col == 3'd7);
    assign w_row_wrap = w_col_wrap & (r_row == 3'd7);
    assign w_col_nxt  = r_col + 3'd1;
    assign w_row_nxt  = w_col_wrap ? (r_row + 3'd1) : r_row;
    assign w_blk_nxt  = w_row_wrap ? (w_is_last_block ? '0 : r_blk + 1'b1) : r_blk;

    // The final sample of the strip is the only one carrying both flags
    assign w_final_pop = (r_state == c_st_drain) & w_pop & r_head_last & r_head_last_block;

    // Controller: start on strip_valid, issue reads, then wait for the drain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_blk        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_raddr      <= '0;
            r_strip_done <= 1'b0;
        end else begin
            r_strip_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (strip_valid) begin
                        r_state <= c_st_read;
                        r_blk   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_raddr <= '0;
                    end
                end
                c_st_read: begin
                    if (w_issue) begin
                        r_blk   <= w_blk_nxt;
                        r_row   <= w_row_nxt;
                        r_col   <= w_col_nxt;
                        r_raddr <= f_addr(w_blk_nxt, w_row_nxt, w_col_nxt);
                        if (w_is_final) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_final_pop) begin
                        r_state      <= c_st_idle;
                        r_strip_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Mark the cycle in which rdata answers an issued address, with its flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_flight     <= 1'b0;
            r_if_last       <= 1'b0;
            r_if_last_block <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_if_last       <= w_is_last;
                r_if_last_block <= w_is_last_block;
            end
        end
    end

    // Skid FIFO: head only changes when it is popped or the FIFO is empty
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count           <= 2'd0;
            r_head_data       <= '0;
            r_head_last       <= 1'b0;
            r_head_last_block <= 1'b0;
            r_tail_data       <= '0;
            r_tail_last       <= 1'b0;
            r_tail_last_block <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data       <= rdata;
                        r_head_last       <= r_if_last;
                        r_head_last_block <= r_if_last_block;
                    end else begin
                        r_tail_data       <= rdata;
                        r_tail_last       <= r_if_last;
                        r_tail_last_block <= r_if_last_block;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_data       <= r_tail_data;
                    r_head_last       <= r_tail_last;
                    r_head_last_block <= r_tail_last_block;
                    r_count           <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head_data       <= rdata;
                        r_head_last       <= r_if_last;
                        r_head_last_block <= r_if_last_block;
                    end else begin
                        r_head_data       <= r_tail_data;
                        r_head_last       <= r_tail_last;
                        r_head_last_block <= r_tail_last_block;
                        r_tail_data       <= rdata;
                        r_tail_last       <= r_if_last;
                        r_tail_last_block <= r_if_last_block;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign raddr           = r_raddr;
    assign strip_done      = r_strip_done;
    assign dout            = r_head_data;
    assign dout_last       = r_head_last;
    assign dout_last_block = r_head_last_block;
    assign dout_valid      = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: doc/ebr_block_reader.md
Name: ebr_block_reader

Overview:
- Downstream consumer of the dual-port EBR line buffer in the JPEG pipeline.
- The EBR holds one 8-line strip of pixels in raster order. This block issues EBR read addresses and re-orders the strip into 8x8 blocks, one sample at a time, in block order and raster order within each block.
- Results go out on a valid/ready stream to the DCT stage.
- It absorbs the EBR's fixed 1-cycle read latency and downstream backpressure without losing or duplicating samples.

Parameters:
- addr_width, 9, EBR address width. Must match the EBR instance.
- data_width, 8, pixel width.
- image_width, 64, pixels per row in the strip. Must be a multiple of 8, and 8*image_width <= 2^addr_width.

Ports:
- clk  in  1  sole clock. Also drives the EBR rclk.
- reset_n  in  1  synchronous, active-low reset.
- strip_valid  in  1  level: a full strip is present in the EBR.
- strip_done  out  1  one-cycle pulse: the last sample of the strip has been accepted downstream.
- raddr  out  addr_width  EBR read address, registered.
- rdata  in  data_width  EBR dout; reflects the raddr of the previous cycle.
- dout  out  data_width  pixel sample.
- dout_valid  out  1  sample valid.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  qualifies dout; high on sample 63 of each block.
- dout_last_block  out  1  qualifies dout; high on every sample of the final block of the strip.

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on the clk rising edge.
- Reset values: raddr=0, dout_valid=0, dout=0, dout_last=0, dout_last_block=0, strip_done=0. State=IDLE, skid FIFO empty, in-flight flag=0, all counters=0.
- Address generation: counters blk (0..image_width/8-1), row (0..7), col (0..7).
  - raddr = row*image_width + blk*8 + col, computed at addr_width bits with no overflow, given the parameter constraint.
  - Advance order: col fastest, then row, then blk.
- State machine:
  - IDLE: wait for strip_valid=1 in cycle T. Enter READ at T+1 with counters at 0.
  - READ: issue one address per cycle while credit is available (see below). After the final address (blk max, row 7, col 7) is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, no read is in flight, and the final sample has handshaken. Pulse strip_done for one cycle, then return to IDLE.
  - strip_valid is ignored outside IDLE. If it is still high in IDLE after strip_done, a new strip starts at address 0.
- Read tracking:
  - The EBR has no read enable. An in_flight register marks the cycle after an address was issued; in that cycle rdata is pushed into the FIFO.
  - raddr holds its value when no read is issued.
- Skid FIFO: 2 entries. dout, dout_last and dout_last_block come from the FIFO head register. dout_valid = FIFO not empty.
  - An issue is allowed when fifo_count + in_flight - pop < 2, where pop = dout_valid & dout_ready in the same cycle.
  - Simultaneous push and pop on a full FIFO is legal and keeps the count at 2.
- Latency and throughput:
  - strip_valid sampled in cycle T gives raddr=0 at T+1, rdata at T+2, and the first dout_valid at T+3.
  - With dout_ready held at 1, one sample is produced per cycle and there are no bubbles within a strip.
- Output stability: while dout_valid=1 and dout_ready=0, dout, dout_last and dout_last_block hold constant.
- Flags: last and last_block are computed when the address is issued and travel with the sample through in_flight and the FIFO.
- Reset mid-operation: the next cycle shows the reset values. The partial strip is discarded and no strip_done is emitted for it.

Test Plan:
1. image_width=64, EBR mem[a]=a[7:0], dout_ready=1, strip_valid at T:
   - first sample at T+3 is 0x00, then 0x01..0x07, then sample 8 = 0x40.
   - sample 63 = 0xC7 with dout_last=1.
   - sample 64 = 0x08.
   - 512 samples in 512 consecutive cycles.
   - strip_done pulses once, one cycle after the last handshake.
2. Same setup with dout_ready driven by a random 50% pattern: the output sequence matches scenario 1 exactly, with no drops or duplicates, and dout is stable whenever valid=1 and ready=0.
3. dout_ready=0 for 20 cycles starting at T+3: raddr stalls after issuing addresses 0 and 1, the FIFO holds 0x00 and 0x01, and the stream resumes in order once ready=1.
4. reset_n=0 for one cycle after 100 accepted samples: the next cycle has dout_valid=0, raddr=0, strip_done=0. A new strip_valid restarts the sequence at 0x00.
5. strip_valid held high through strip_done: a second strip starts from IDLE and its first sample is again mem[0]=0x00.
6. image_width=8 (single block): 64 samples are produced; dout_last_block=1 on all of them, dout_last=1 only on sample 63, and strip_done follows.
